// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the ID/EX control bundle.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned IMM_W   = 16;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_AND  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_NOR  = 3'b011;
  localparam logic [2:0] ALU_ADDU = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b101;

  typedef struct packed {
    logic       alu_src;
    logic [2:0] alu_control;
    logic       reg_dst;
    logic       alu_enable;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       branch;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: control bundle, extended immediate,
// illegal-encoding pulse and whether rt is a source operand.
module ctrl_decode
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [INSTR_W-1:0] instr,
  output ctrl_t              ctrl,
  output logic [DATA_W-1:0]  imm,
  output logic               illegal_c,
  output logic               uses_rt_c
);

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] imm_zext;

  assign opcode   = instr[31:26];
  assign funct    = instr[5:0];
  assign imm_sext = {{(DATA_W-IMM_W){instr[15]}}, instr[15:0]};
  assign imm_zext = {{(DATA_W-IMM_W){1'b0}}, instr[15:0]};

  always_comb begin
    ctrl      = '0;
    imm       = imm_sext;
    illegal_c = 1'b0;
    uses_rt_c = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        uses_rt_c       = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.alu_enable = 1'b1;
        case (funct)
          FN_ADD:          ctrl.alu_control = ALU_ADD;
          FN_ADDU:         ctrl.alu_control = ALU_ADDU;
          FN_SUB, FN_SUBU: ctrl.alu_control = ALU_SUB;
          FN_AND:          ctrl.alu_control = ALU_AND;
          FN_OR:           ctrl.alu_control = ALU_OR;
          FN_NOR:          ctrl.alu_control = ALU_NOR;
          default: begin
            // The all-zero word is the canonical nop: issued inert but not flagged.
            ctrl      = '0;
            illegal_c = (instr != '0);
          end
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
        ctrl.alu_enable  = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = (opcode == OP_ADDIU) ? ALU_ADDU : ALU_ADD;
        ctrl.mem_read    = (opcode == OP_LW);
        ctrl.mem_write   = (opcode == OP_SW);
        ctrl.reg_write   = (opcode != OP_SW);
        uses_rt_c        = (opcode == OP_SW);
      end
      OP_ANDI, OP_ORI: begin
        ctrl.alu_enable  = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.reg_write   = 1'b1;
        ctrl.alu_control = (opcode == OP_ANDI) ? ALU_AND : ALU_OR;
        imm              = imm_zext;
      end
      OP_BEQ: begin
        ctrl.alu_enable  = 1'b1;
        ctrl.alu_control = ALU_SUB;
        ctrl.branch      = 1'b1;
        uses_rt_c        = 1'b1;
      end
      default: illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_issue.sv
// Decode-and-issue stage: ID/EX pipeline register with valid/ready handshake,
// load-use bubble insertion and branch flush.
module id_ex_issue
  import mips_pkg::*;
#(
  parameter int unsigned PC_W   = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [INSTR_W-1:0]  instr,
  input  logic [PC_W-1:0]     pc_in,
  input  logic [DATA_W-1:0]   rd_data1,
  input  logic [DATA_W-1:0]   rd_data2,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                ex_ready,
  input  logic                flush,
  output logic                out_valid,
  output logic [PC_W-1:0]     PC,
  output logic [DATA_W-1:0]   In,
  output logic [REG_W-1:0]    Reg_RD,
  output logic [REG_W-1:0]    Reg_RT,
  output logic [DATA_W-1:0]   Dato_1,
  output logic [DATA_W-1:0]   Dato_2,
  output logic                ALUsrc,
  output logic [2:0]          ALUcontrol,
  output logic                Regdst,
  output logic                ALU_enable,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                RegWrite,
  output logic                Branch,
  output logic                illegal
);

  ctrl_t             dec_ctrl;
  logic [DATA_W-1:0] dec_imm;
  logic              dec_illegal_c;
  logic              uses_rt_c;
  logic              advance;
  logic              haz;

  ctrl_t             ctrl_q,    ctrl_d;
  logic              valid_q,   valid_d;
  logic              illegal_q, illegal_d;
  logic [PC_W-1:0]   pc_q,      pc_d;
  logic [DATA_W-1:0] imm_q,     imm_d;
  logic [REG_W-1:0]  rd_q,      rd_d;
  logic [REG_W-1:0]  rt_q,      rt_d;
  logic [DATA_W-1:0] dat1_q,    dat1_d;
  logic [DATA_W-1:0] dat2_q,    dat2_d;

  ctrl_decode #(.DATA_W(DATA_W)) u_ctrl_decode (
    .instr     (instr),
    .ctrl      (dec_ctrl),
    .imm       (dec_imm),
    .illegal_c (dec_illegal_c),
    .uses_rt_c (uses_rt_c)
  );

  // A load in ID/EX whose destination feeds the instruction in ID stalls it one cycle.
  assign advance  = !valid_q || ex_ready;
  assign haz      = valid_q && ctrl_q.mem_read && (rt_q != '0) &&
                    ((rt_q == instr[25:21]) || (uses_rt_c && (rt_q == instr[20:16])));
  assign in_ready = advance && !haz && !flush;

  always_comb begin
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    illegal_d = illegal_q;
    pc_d      = pc_q;
    imm_d     = imm_q;
    rd_d      = rd_q;
    rt_d      = rt_q;
    dat1_d    = dat1_q;
    dat2_d    = dat2_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (advance) begin
      if (haz || !in_valid) begin
        valid_d = 1'b0;
        ctrl_d  = '0;
      end else begin
        valid_d   = 1'b1;
        ctrl_d    = dec_ctrl;
        illegal_d = illegal_q | dec_illegal_c;
        pc_d      = pc_in;
        imm_d     = dec_imm;
        rd_d      = instr[15:11];
        rt_d      = instr[20:16];
        dat1_d    = rd_data1;
        dat2_d    = rd_data2;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
      pc_q      <= '0;
      imm_q     <= '0;
      rd_q      <= '0;
      rt_q      <= '0;
      dat1_q    <= '0;
      dat2_q    <= '0;
    end else begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
      pc_q      <= pc_d;
      imm_q     <= imm_d;
      rd_q      <= rd_d;
      rt_q      <= rt_d;
      dat1_q    <= dat1_d;
      dat2_q    <= dat2_d;
    end
  end

  assign out_valid  = valid_q;
  assign illegal    = illegal_q;
  assign PC         = pc_q;
  assign In         = imm_q;
  assign Reg_RD     = rd_q;
  assign Reg_RT     = rt_q;
  assign Dato_1     = dat1_q;
  assign Dato_2     = dat2_q;
  assign ALUsrc     = ctrl_q.alu_src;
  assign ALUcontrol = ctrl_q.alu_control;
  assign Regdst     = ctrl_q.reg_dst;
  assign ALU_enable = ctrl_q.alu_enable;
  assign MemRead    = ctrl_q.mem_read;
  assign MemWrite   = ctrl_q.mem_write;
  assign RegWrite   = ctrl_q.reg_write;
  assign Branch     = ctrl_q.branch;

endmodule

// File: tb/tb_id_ex_issue.sv
// Directed bench for id_ex_issue: decode, load-use bubble, backpressure,
// flush, illegal tracking and asynchronous reset.
module tb_id_ex_issue;

  localparam int unsigned PC_W   = 5;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       instr;
  logic [PC_W-1:0]   pc_in;
  logic [DATA_W-1:0] rd_data1, rd_data2;
  logic              in_valid, in_ready, ex_ready, flush, out_valid;
  logic [PC_W-1:0]   PC;
  logic [DATA_W-1:0] In, Dato_1, Dato_2;
  logic [4:0]        Reg_RD, Reg_RT;
  logic              ALUsrc, Regdst, ALU_enable, MemRead, MemWrite, RegWrite, Branch, illegal;
  logic [2:0]        ALUcontrol;

  int tests = 0;
  int fails = 0;

  id_ex_issue #(.PC_W(PC_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .instr(instr), .pc_in(pc_in),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .in_valid(in_valid),
    .in_ready(in_ready), .ex_ready(ex_ready), .flush(flush),
    .out_valid(out_valid), .PC(PC), .In(In), .Reg_RD(Reg_RD), .Reg_RT(Reg_RT),
    .Dato_1(Dato_1), .Dato_2(Dato_2), .ALUsrc(ALUsrc), .ALUcontrol(ALUcontrol),
    .Regdst(Regdst), .ALU_enable(ALU_enable), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .Branch(Branch), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [PC_W-1:0] p,
                       input logic [31:0] a, input logic [31:0] b);
    instr    = i;
    pc_in    = p;
    rd_data1 = a;
    rd_data2 = b;
    in_valid = 1'b1;
  endtask

  initial begin
    reset = 1'b1; instr = '0; pc_in = '0; rd_data1 = '0; rd_data2 = '0;
    in_valid = 1'b0; ex_ready = 1'b1; flush = 1'b0;
    tick(); tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_regwrite", 32'(RegWrite), 32'd0);
    reset = 1'b0;

    // nop: issued inert, illegal stays clear
    drive(32'h0000_0000, 5'd0, 32'd0, 32'd0);
    tick();
    check("nop_valid", 32'(out_valid), 32'd1);
    check("nop_alu_en", 32'(ALU_enable), 32'd0);
    check("nop_regwrite", 32'(RegWrite), 32'd0);
    check("nop_illegal", 32'(illegal), 32'd0);

    // add $3,$1,$2
    drive(32'h0022_1820, 5'd1, 32'd5, 32'd7);
    #1 check("add_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("add_valid", 32'(out_valid), 32'd1);
    check("add_aluctl", 32'(ALUcontrol), 32'd0);
    check("add_regdst", 32'(Regdst), 32'd1);
    check("add_alusrc", 32'(ALUsrc), 32'd0);
    check("add_rd", 32'(Reg_RD), 32'd3);
    check("add_dat1", Dato_1, 32'd5);
    check("add_dat2", Dato_2, 32'd7);
    check("add_regwrite", 32'(RegWrite), 32'd1);
    check("add_pc", 32'(PC), 32'd1);

    // andi $4,$1,0xFFFF (zero-extend)
    drive(32'h3024_FFFF, 5'd2, 32'd5, 32'd7);
    tick();
    check("andi_imm", In, 32'h0000_FFFF);
    check("andi_aluctl", 32'(ALUcontrol), 32'd1);
    check("andi_alusrc", 32'(ALUsrc), 32'd1);
    check("andi_regdst", 32'(Regdst), 32'd0);
    check("andi_rt", 32'(Reg_RT), 32'd4);

    // addi $4,$1,-1 (sign-extend)
    drive(32'h2024_FFFF, 5'd3, 32'd5, 32'd7);
    tick();
    check("addi_imm", In, 32'hFFFF_FFFF);
    check("addi_aluctl", 32'(ALUcontrol), 32'd0);

    // lw $2,0($1) then dependent add $3,$2,$2
    drive(32'h8C22_0000, 5'd4, 32'd1, 32'd0);
    tick();
    check("lw_memread", 32'(MemRead), 32'd1);
    check("lw_rt", 32'(Reg_RT), 32'd2);
    drive(32'h0042_1820, 5'd5, 32'd9, 32'd9);
    #1 check("lu_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("lu_bubble_valid", 32'(out_valid), 32'd0);
    check("lu_bubble_memread", 32'(MemRead), 32'd0);
    check("lu_bubble_regwrite", 32'(RegWrite), 32'd0);
    check("lu_ready_after", 32'(in_ready), 32'd1);
    tick();
    check("lu_issue_valid", 32'(out_valid), 32'd1);
    check("lu_issue_pc", 32'(PC), 32'd5);
    check("lu_issue_rd", 32'(Reg_RD), 32'd3);

    // lw $2 then independent add $3,$4,$5: no bubble
    drive(32'h8C22_0000, 5'd6, 32'd1, 32'd0);
    tick();
    drive(32'h0085_1820, 5'd7, 32'd4, 32'd5);
    #1 check("nolu_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("nolu_valid", 32'(out_valid), 32'd1);
    check("nolu_pc", 32'(PC), 32'd7);

    // backpressure: hold for three cycles
    ex_ready = 1'b0;
    drive(32'h3405_1234, 5'd8, 32'd0, 32'd0);
    for (int k = 0; k < 3; k++) begin
      #1 check("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_pc", 32'(PC), 32'd7);
      check("bp_dat2", Dato_2, 32'd5);
    end
    ex_ready = 1'b1;
    #1 check("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    check("ori_pc", 32'(PC), 32'd8);
    check("ori_imm", In, 32'h0000_1234);
    check("ori_aluctl", 32'(ALUcontrol), 32'd2);

    // beq $1,$2,+4 then flush with a valid input pending
    drive(32'h1022_0004, 5'd9, 32'd1, 32'd2);
    tick();
    check("beq_branch", 32'(Branch), 32'd1);
    check("beq_aluctl", 32'(ALUcontrol), 32'd5);
    check("beq_imm", In, 32'd4);
    check("beq_alusrc", 32'(ALUsrc), 32'd0);
    flush = 1'b1;
    drive(32'h0022_1820, 5'd10, 32'd5, 32'd7);
    #1 check("fl_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_branch", 32'(Branch), 32'd0);
    flush = 1'b0;
    in_valid = 1'b0;
    tick();
    check("idle_valid", 32'(out_valid), 32'd0);

    // illegal opcode 0x3F, then nop keeps illegal set
    drive(32'hFC00_0000, 5'd11, 32'd0, 32'd0);
    tick();
    check("ill_valid", 32'(out_valid), 32'd1);
    check("ill_alu_en", 32'(ALU_enable), 32'd0);
    check("ill_regwrite", 32'(RegWrite), 32'd0);
    check("ill_flag", 32'(illegal), 32'd1);
    drive(32'h0000_0000, 5'd12, 32'h55, 32'h66);
    tick();
    check("ill_sticky", 32'(illegal), 32'd1);
    check("ill_nop_valid", 32'(out_valid), 32'd1);
    check("ill_nop_dat1", Dato_1, 32'h55);

    // asynchronous reset between clock edges
    #1 reset = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_illegal", 32'(illegal), 32'd0);
    check("arst_dat1", Dato_1, 32'd0);
    check("arst_pc", 32'(PC), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
